spi_txn_arbiter: RTL and testbench

Shares one SPI controller engine among `REQ_CNT` requesters, such as core load/store ports or a DMA channel. Requests are accepted round-robin. For each accepted request the block loads the engine's write data, mode, byte count and chip select, then runs the transaction. It waits for the engine's end-of-transaction, with an optional timeout, and returns read data and status to the granted requester. The block sits between the requesters and the SPI controller, and is the only block that drives the engine's control inputs.

---
 rtl/spi_txn_arbiter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//
// Shares one SPI controller engine among REQ_CNT requesters. Requests are
// accepted round-robin, one transaction outstanding at a time. For each grant
// the block parallel-loads the engine (data, mode, byte count, chip select),
// runs the transaction until eng_end_txn or an optional timeout, then returns
// read data and error status to the granted requester.
//
// Ports:
//   clk, sync_rst_n        clock, asynchronous active-low reset
//   clk_en                 qualifies every state and register update
//   req_valid/mode/byte_sel/peri/wr_data   per-requester request fields
//   req_grant              one-hot pulse, request accepted and captured
//   rsp_valid/rd_data/err  one-hot completion pulse with data and status
//   busy                   high from grant until the cycle after rsp_valid
//   eng_*                  engine control outputs; eng_end_txn/eng_rd_data inputs
//
// All outputs are registered: each output reflects the decision made in the
// state of the previous enabled cycle, so a pulse holds through clk_en=0 cycles.
module spi_txn_arbiter #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned PERI_CNT       = 4,
  parameter int unsigned REQ_CNT        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned PeriW         = (PERI_CNT > 1) ? $clog2(PERI_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          sync_rst_n,
  input  logic                          clk_en,
  input  logic [REQ_CNT-1:0]            req_valid,
  input  logic [2*REQ_CNT-1:0]          req_mode,
  input  logic [3*REQ_CNT-1:0]          req_byte_sel,
  input  logic [PeriW*REQ_CNT-1:0]      req_peri,
  input  logic [DATA_WIDTH*REQ_CNT-1:0] req_wr_data,
  output logic [REQ_CNT-1:0]            req_grant,
  output logic [REQ_CNT-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rd_data,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          eng_wr_en,
  output logic                          eng_start_txn,
  output logic [1:0]                    eng_spi_mode,
  output logic [2:0]                    eng_byte_sel,
  output logic [DATA_WIDTH-1:0]         eng_wr_data,
  output logic [PERI_CNT-1:0]           eng_chip_sel_one_cold,
  input  logic                          eng_end_txn,
  input  logic [DATA_WIDTH-1:0]         eng_rd_data
);

  localparam int unsigned IdxW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(REQ_CNT - 1);
  localparam logic [IdxW:0]    ReqCntS  = (IdxW + 1)'(REQ_CNT);
  localparam logic [PeriW:0]   PeriCntS = (PeriW + 1)'(PERI_CNT);
  localparam logic [CntW-1:0]  CntLast  = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StXfer, StResp} state_e;

  state_e                  r_state, w_state_d;
  logic [IdxW-1:0]         r_rr_ptr, w_rr_ptr_d;
  logic [IdxW-1:0]         r_win, w_win_d;
  logic [1:0]              r_mode, w_mode_d;
  logic [2:0]              r_bsel, w_bsel_d;
  logic [PeriW-1:0]        r_peri, w_peri_d;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_d;
  logic [CntW-1:0]         r_cnt, w_cnt_d;
  logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_d;
  logic                    r_err, w_err_d;

  logic [REQ_CNT-1:0]      r_req_grant, w_req_grant_d;
  logic [REQ_CNT-1:0]      r_rsp_valid, w_rsp_valid_d;
  logic [DATA_WIDTH-1:0]   r_rsp_rd_data, w_rsp_rd_data_d;
  logic                    r_rsp_err, w_rsp_err_d;
  logic                    r_busy, w_busy_d;
  logic                    r_eng_wr_en, w_eng_wr_en_d;
  logic                    r_eng_start, w_eng_start_d;
  logic [1:0]              r_eng_mode, w_eng_mode_d;
  logic [2:0]              r_eng_bsel, w_eng_bsel_d;
  logic [DATA_WIDTH-1:0]   r_eng_wdata, w_eng_wdata_d;
  logic [PERI_CNT-1:0]     r_eng_cs, w_eng_cs_d;

  // Round-robin winner: first set request scanning upward from r_rr_ptr.
  logic                    w_found;
  logic [IdxW-1:0]         w_win;
  logic [IdxW:0]           w_scan;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int unsigned i = 0; i < REQ_CNT; i++) begin
      w_scan = {1'b0, r_rr_ptr} + (IdxW + 1)'(i);
      if (w_scan >= ReqCntS) w_scan = w_scan - ReqCntS;
      if (!w_found && req_valid[w_scan[IdxW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_scan[IdxW-1:0];
      end
    end
  end

  logic [1:0]            w_sel_mode;
  logic [2:0]            w_sel_bsel;
  logic [PeriW-1:0]      w_sel_peri;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_peri_bad;

  assign w_sel_mode  = req_mode[w_win*2 +: 2];
  assign w_sel_bsel  = req_byte_sel[w_win*3 +: 3];
  assign w_sel_peri  = req_peri[w_win*PeriW +: PeriW];
  assign w_sel_wdata = req_wr_data[w_win*DATA_WIDTH +: DATA_WIDTH];
  // Index field may be wide enough to name a peripheral that does not exist.
  assign w_peri_bad  = ({1'b0, w_sel_peri} >= PeriCntS);

  // One-cold chip select for the captured peripheral.
  logic [PERI_CNT-1:0] w_cs_dec;

  always_comb begin
    w_cs_dec = '1;
    for (int unsigned p = 0; p < PERI_CNT; p++) begin
      if (r_peri == PeriW'(p)) w_cs_dec[p] = 1'b0;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_rr_ptr_d      = r_rr_ptr;
    w_win_d         = r_win;
    w_mode_d        = r_mode;
    w_bsel_d        = r_bsel;
    w_peri_d        = r_peri;
    w_wdata_d       = r_wdata;
    w_cnt_d         = r_cnt;
    w_rdata_d       = r_rdata;
    w_err_d         = r_err;
    w_req_grant_d   = '0;
    w_rsp_valid_d   = '0;
    w_rsp_rd_data_d = '0;
    w_rsp_err_d     = 1'b0;
    w_eng_wr_en_d   = 1'b0;
    w_eng_start_d   = 1'b0;
    w_eng_mode_d    = r_eng_mode;
    w_eng_bsel_d    = r_eng_bsel;
    w_eng_wdata_d   = r_eng_wdata;
    w_eng_cs_d      = '1;

    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_win_d                = w_win;
          w_mode_d               = w_sel_mode;
          w_bsel_d               = w_sel_bsel;
          w_peri_d               = w_sel_peri;
          w_wdata_d              = w_sel_wdata;
          w_rr_ptr_d             = (w_win == LastIdx) ? '0 : w_win + 1'b1;
          w_req_grant_d[w_win]   = 1'b1;
          w_rdata_d              = '0;
          if (w_peri_bad) begin
            w_err_d   = 1'b1;
            w_state_d = StResp;
          end else begin
            w_err_d   = 1'b0;
            w_state_d = StLoad;
          end
        end
      end
      StLoad: begin
        w_eng_wr_en_d = 1'b1;
        w_eng_mode_d  = r_mode;
        w_eng_bsel_d  = r_bsel;
        w_eng_wdata_d = r_wdata;
        w_eng_cs_d    = w_cs_dec;
        w_cnt_d       = '0;
        w_state_d     = StXfer;
      end
      StXfer: begin
        w_eng_start_d = 1'b1;
        w_eng_cs_d    = w_cs_dec;
        // End of transaction wins over a timeout in the same cycle.
        if (eng_end_txn) begin
          w_rdata_d = eng_rd_data;
          w_err_d   = 1'b0;
          w_state_d = StResp;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CntLast)) begin
          w_rdata_d = '0;
          w_err_d   = 1'b1;
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StResp: begin
        w_rsp_valid_d[r_win] = 1'b1;
        w_rsp_rd_data_d      = r_rdata;
        w_rsp_err_d          = r_err;
        w_state_d            = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Covers the registered rsp_valid cycle, which lands while the FSM is IDLE.
    w_busy_d = (r_state != StIdle) || (w_state_d != StIdle);
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_win         <= '0;
      r_mode        <= '0;
      r_bsel        <= '0;
      r_peri        <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_req_grant   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rd_data <= '0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
      r_eng_wr_en   <= 1'b0;
      r_eng_start   <= 1'b0;
      r_eng_mode    <= '0;
      r_eng_bsel    <= '0;
      r_eng_wdata   <= '0;
      r_eng_cs      <= '1;
    end else if (clk_en) begin
      r_state       <= w_state_d;
      r_rr_ptr      <= w_rr_ptr_d;
      r_win         <= w_win_d;
      r_mode        <= w_mode_d;
      r_bsel        <= w_bsel_d;
      r_peri        <= w_peri_d;
      r_wdata       <= w_wdata_d;
      r_cnt         <= w_cnt_d;
      r_rdata       <= w_rdata_d;
      r_err         <= w_err_d;
      r_req_grant   <= w_req_grant_d;
      r_rsp_valid   <= w_rsp_valid_d;
      r_rsp_rd_data <= w_rsp_rd_data_d;
      r_rsp_err     <= w_rsp_err_d;
      r_busy        <= w_busy_d;
      r_eng_wr_en   <= w_eng_wr_en_d;
      r_eng_start   <= w_eng_start_d;
      r_eng_mode    <= w_eng_mode_d;
      r_eng_bsel    <= w_eng_bsel_d;
      r_eng_wdata   <= w_eng_wdata_d;
      r_eng_cs      <= w_eng_cs_d;
    end
  end

  assign req_grant             = r_req_grant;
  assign rsp_valid             = r_rsp_valid;
  assign rsp_rd_data           = r_rsp_rd_data;
  assign rsp_err               = r_rsp_err;
  assign busy                  = r_busy;
  assign eng_wr_en             = r_eng_wr_en;
  assign eng_start_txn         = r_eng_start;
  assign eng_spi_mode          = r_eng_mode;
  assign eng_byte_sel          = r_eng_bsel;
  assign eng_wr_data           = r_eng_wdata;
  assign eng_chip_sel_one_cold = r_eng_cs;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter. Main instance: 4 peripherals, 2
// requesters, 16-cycle timeout. A second instance with 3 peripherals lets an
// out-of-range peripheral index be requested.
module tb_spi_txn_arbiter;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic [1:0]    req_valid;
  logic [1:0]    req_valid3;
  logic [3:0]    req_mode;
  logic [5:0]    req_byte_sel;
  logic [3:0]    req_peri;
  logic [2*DW-1:0] req_wr_data;
  logic          end_txn;
  logic [DW-1:0] rd_data;

  logic [1:0]    req_grant, rsp_valid;
  logic [DW-1:0] rsp_rd_data, eng_wr_data;
  logic          rsp_err, busy, eng_wr_en, eng_start;
  logic [1:0]    eng_mode;
  logic [2:0]    eng_bsel;
  logic [3:0]    eng_cs;

  logic [1:0]    req_grant3, rsp_valid3;
  logic [DW-1:0] rsp_rd_data3, eng_wr_data3;
  logic          rsp_err3, busy3, eng_wr_en3, eng_start3;
  logic [1:0]    eng_mode3;
  logic [2:0]    eng_bsel3;
  logic [2:0]    eng_cs3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_txn_arbiter #(
    .DATA_WIDTH(DW), .PERI_CNT(4), .REQ_CNT(2), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk(clk), .sync_rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_mode(req_mode), .req_byte_sel(req_byte_sel),
    .req_peri(req_peri), .req_wr_data(req_wr_data),
    .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
    .rsp_err(rsp_err), .busy(busy), .eng_wr_en(eng_wr_en), .eng_start_txn(eng_start),
    .eng_spi_mode(eng_mode), .eng_byte_sel(eng_bsel), .eng_wr_data(eng_wr_data),
    .eng_chip_sel_one_cold(eng_cs), .eng_end_txn(end_txn), .eng_rd_data(rd_data)
  );

  spi_txn_arbiter #(
    .DATA_WIDTH(DW), .PERI_CNT(3), .REQ_CNT(2), .TIMEOUT_CYCLES(16)
  ) u_dut3 (
    .clk(clk), .sync_rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid3), .req_mode(req_mode), .req_byte_sel(req_byte_sel),
    .req_peri(req_peri), .req_wr_data(req_wr_data),
    .req_grant(req_grant3), .rsp_valid(rsp_valid3), .rsp_rd_data(rsp_rd_data3),
    .rsp_err(rsp_err3), .busy(busy3), .eng_wr_en(eng_wr_en3), .eng_start_txn(eng_start3),
    .eng_spi_mode(eng_mode3), .eng_byte_sel(eng_bsel3), .eng_wr_data(eng_wr_data3),
    .eng_chip_sel_one_cold(eng_cs3), .eng_end_txn(end_txn), .eng_rd_data(rd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] mode, input logic [2:0] bsel,
                         input logic [1:0] peri, input logic [DW-1:0] data);
    req_mode[r*2 +: 2]      = mode;
    req_byte_sel[r*3 +: 3]  = bsel;
    req_peri[r*2 +: 2]      = peri;
    req_wr_data[r*DW +: DW] = data;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; req_valid = '0; req_valid3 = '0;
    req_mode = '0; req_byte_sel = '0; req_peri = '0; req_wr_data = '0;
    end_txn = 1'b0; rd_data = '0;
    step(); step(); step();
    checks++;
    if ({req_grant, rsp_valid, rsp_err, busy, eng_wr_en, eng_start} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {req_grant, rsp_valid, rsp_err, busy, eng_wr_en, eng_start});
    end
    checks++;
    if ({rsp_rd_data, eng_wr_data, eng_mode, eng_bsel} !== '0) begin
      failures++;
      $display("FAIL reset_data: got rd=%h wd=%h mode=%b bsel=%b want all 0",
               rsp_rd_data, eng_wr_data, eng_mode, eng_bsel);
    end
    checks++;
    if (eng_cs !== 4'b1111 || eng_cs3 !== 3'b111) begin
      failures++;
      $display("FAIL reset_cs: got %b/%b want 1111/111", eng_cs, eng_cs3);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || req_grant !== 2'b00) begin
      failures++;
      $display("FAIL reset_release: got busy=%b grant=%b want 0/00", busy, req_grant);
    end
  endtask

  task automatic test_single();
    set_req(0, 2'b01, 3'd3, 2'd2, 16'h00A5);
    req_valid = 2'b01;
    step();  // grant cycle g
    checks++;
    if (req_grant !== 2'b01 || busy !== 1'b1 || eng_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: got grant=%b busy=%b wr=%b want 01/1/0",
               req_grant, busy, eng_wr_en);
    end
    req_valid = 2'b00;
    step();  // g+1
    checks++;
    if (eng_wr_en !== 1'b1 || eng_wr_data !== 16'h00A5 || eng_mode !== 2'b01 ||
        eng_bsel !== 3'd3 || eng_start !== 1'b0 || req_grant !== 2'b00) begin
      failures++;
      $display("FAIL single_load: got wr=%b wd=%h mode=%b bsel=%0d start=%b grant=%b",
               eng_wr_en, eng_wr_data, eng_mode, eng_bsel, eng_start, req_grant);
    end
    checks++;
    if (eng_cs !== 4'b1011) begin
      failures++;
      $display("FAIL single_cs_load: got %b want 1011", eng_cs);
    end
    step();  // g+2: first cycle with start high
    checks++;
    if (eng_start !== 1'b1 || eng_wr_en !== 1'b0 || eng_cs !== 4'b1011) begin
      failures++;
      $display("FAIL single_xfer: got start=%b wr=%b cs=%b want 1/0/1011",
               eng_start, eng_wr_en, eng_cs);
    end
    repeat (10) step();  // g+12
    checks++;
    if (eng_start !== 1'b1 || eng_cs !== 4'b1011 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_hold: got start=%b cs=%b rsp=%b want 1/1011/00",
               eng_start, eng_cs, rsp_valid);
    end
    rd_data = 16'h003C;
    end_txn = 1'b1;
    step();  // g+13
    end_txn = 1'b0;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_early_rsp: got %b want 00", rsp_valid);
    end
    step();  // g+14
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rd_data !== 16'h003C || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got v=%b d=%h e=%b want 01/003c/0",
               rsp_valid, rsp_rd_data, rsp_err);
    end
    checks++;
    if (eng_start !== 1'b0 || eng_cs !== 4'b1111 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_rsp_eng: got start=%b cs=%b busy=%b want 0/1111/1",
               eng_start, eng_cs, busy);
    end
    step();  // g+15
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got rsp=%b busy=%b want 00/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_req(0, 2'b00, 3'd0, 2'd0, 16'hAAAA);
    set_req(1, 2'b11, 3'd1, 2'd3, 16'hBBBB);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]    exp_g;
      logic [DW-1:0] exp_d;
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_d = (k % 2 == 1) ? 16'hBBBB : 16'hAAAA;
      step();  // g
      checks++;
      if (req_grant !== exp_g) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b want %b", k, req_grant, exp_g);
      end
      step();  // g+1, first XFER state cycle
      checks++;
      if (eng_wr_data !== exp_d) begin
        failures++;
        $display("FAIL rr_wdata[%0d]: got %h want %h", k, eng_wr_data, exp_d);
      end
      end_txn = 1'b1;
      rd_data = 16'h1000 + 16'(k);
      step();  // g+2
      end_txn = 1'b0;
      step();  // g+3
      checks++;
      if (rsp_valid !== exp_g || rsp_rd_data !== 16'h1000 + 16'(k)) begin
        failures++;
        $display("FAIL rr_rsp[%0d]: got v=%b d=%h want %b/%h", k, rsp_valid, rsp_rd_data,
                 exp_g, 16'h1000 + 16'(k));
      end
      if (k == 3) req_valid = 2'b00;
    end
    step();
    checks++;
    if (busy !== 1'b0 || req_grant !== 2'b00) begin
      failures++;
      $display("FAIL rr_idle: got busy=%b grant=%b want 0/00", busy, req_grant);
    end
  endtask

  task automatic test_timeout();
    int n_start = 0;
    int rsp_k   = -1;
    logic [1:0]    rv = '0;
    logic          re = 1'b0;
    logic [DW-1:0] rd = '1;
    logic [3:0]    rc = '0;
    set_req(0, 2'b10, 3'd7, 2'd1, 16'h1234);
    rd_data = 16'hDEAD;
    req_valid = 2'b01;
    step();
    checks++;
    if (req_grant !== 2'b01) begin
      failures++;
      $display("FAIL to_grant: got %b want 01", req_grant);
    end
    req_valid = 2'b00;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 1) begin
        checks++;
        if (eng_cs !== 4'b1101) begin
          failures++;
          $display("FAIL to_cs: got %b want 1101", eng_cs);
        end
      end
      if (eng_start === 1'b1) n_start++;
      if (rsp_valid !== 2'b00 && rsp_k < 0) begin
        rsp_k = k; rv = rsp_valid; re = rsp_err; rd = rsp_rd_data; rc = eng_cs;
      end
    end
    checks++;
    if (n_start != 16) begin
      failures++;
      $display("FAIL to_start_len: got %0d want 16", n_start);
    end
    checks++;
    if (rsp_k != 18 || rv !== 2'b01) begin
      failures++;
      $display("FAIL to_rsp_time: got cycle %0d v=%b want 18/01", rsp_k, rv);
    end
    checks++;
    if (re !== 1'b1 || rd !== 16'h0000 || rc !== 4'b1111) begin
      failures++;
      $display("FAIL to_rsp: got err=%b d=%h cs=%b want 1/0000/1111", re, rd, rc);
    end
  endtask

  task automatic test_timeout_collision();
    int rsp_k = -1;
    logic [1:0]    rv = '0;
    logic          re = 1'b1;
    logic [DW-1:0] rd = '0;
    set_req(1, 2'b11, 3'd0, 2'd3, 16'h5555);
    rd_data = 16'h7777;
    req_valid = 2'b10;
    step();
    checks++;
    if (req_grant !== 2'b10) begin
      failures++;
      $display("FAIL col_grant: got %b want 10", req_grant);
    end
    req_valid = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      step();
      end_txn = (k == 16);  // 16th XFER cycle is also the timeout cycle
      if (rsp_valid !== 2'b00 && rsp_k < 0) begin
        rsp_k = k; rv = rsp_valid; re = rsp_err; rd = rsp_rd_data;
      end
    end
    end_txn = 1'b0;
    checks++;
    if (rsp_k != 18 || rv !== 2'b10) begin
      failures++;
      $display("FAIL col_rsp_time: got cycle %0d v=%b want 18/10", rsp_k, rv);
    end
    checks++;
    if (re !== 1'b0 || rd !== 16'h7777) begin
      failures++;
      $display("FAIL col_rsp: got err=%b d=%h want 0/7777", re, rd);
    end
  endtask

  task automatic test_invalid_index();
    set_req(0, 2'b01, 3'd2, 2'd3, 16'h9999);
    req_valid3 = 2'b01;
    step();
    checks++;
    if (req_grant3 !== 2'b01 || busy3 !== 1'b1 || eng_wr_en3 !== 1'b0) begin
      failures++;
      $display("FAIL inv_grant: got grant=%b busy=%b wr=%b want 01/1/0",
               req_grant3, busy3, eng_wr_en3);
    end
    req_valid3 = 2'b00;
    step();
    checks++;
    if (rsp_valid3 !== 2'b01 || rsp_err3 !== 1'b1 || rsp_rd_data3 !== 16'h0000 ||
        eng_wr_en3 !== 1'b0 || busy3 !== 1'b1) begin
      failures++;
      $display("FAIL inv_rsp: got v=%b e=%b d=%h wr=%b busy=%b want 01/1/0000/0/1",
               rsp_valid3, rsp_err3, rsp_rd_data3, eng_wr_en3, busy3);
    end
    step();
    checks++;
    if (rsp_valid3 !== 2'b00 || busy3 !== 1'b0 || eng_wr_en3 !== 1'b0 ||
        eng_cs3 !== 3'b111) begin
      failures++;
      $display("FAIL inv_idle: got v=%b busy=%b wr=%b cs=%b want 00/0/0/111",
               rsp_valid3, busy3, eng_wr_en3, eng_cs3);
    end
  endtask

  task automatic test_clk_en_stall();
    logic [3:0] pat = 4'b1001;  // clk_en per cycle: 1,0,0,1,...
    int n = 0;                  // enabled edges seen since the request
    set_req(0, 2'b00, 3'd1, 2'd0, 16'h0F0F);
    rd_data = 16'h4242;
    end_txn = 1'b1;  // held: must only matter in XFER
    req_valid = 2'b01;
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (req_grant !== ((n == 1) ? 2'b01 : 2'b00) || eng_wr_en !== (n == 2) ||
          eng_start !== (n == 3) || rsp_valid !== ((n == 4) ? 2'b01 : 2'b00) ||
          busy !== (n >= 1 && n <= 4)) begin
        failures++;
        $display("FAIL stall_pulses[c%0d n%0d]: got g=%b wr=%b st=%b v=%b busy=%b",
                 c, n, req_grant, eng_wr_en, eng_start, rsp_valid, busy);
      end
      if (n == 2 || n == 3) begin
        checks++;
        if (eng_cs !== 4'b1110) begin
          failures++;
          $display("FAIL stall_cs[c%0d]: got %b want 1110", c, eng_cs);
        end
      end
      if (n == 4) begin
        checks++;
        if (rsp_rd_data !== 16'h4242 || rsp_err !== 1'b0) begin
          failures++;
          $display("FAIL stall_rsp[c%0d]: got d=%h e=%b want 4242/0", c, rsp_rd_data, rsp_err);
        end
      end
      if (n >= 1) req_valid = 2'b00;
      clk_en = pat[c % 4];
      step();
      if (clk_en) n++;
    end
    clk_en = 1'b1;
    end_txn = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    bit saw_rsp = 1'b0;
    set_req(0, 2'b01, 3'd2, 2'd2, 16'hCAFE);
    set_req(1, 2'b10, 3'd4, 2'd1, 16'hBEEF);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    step();  // XFER, start high
    checks++;
    if (eng_start !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got start=%b want 1", eng_start);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (eng_start !== 1'b0 || eng_cs !== 4'b1111 || busy !== 1'b0 || eng_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got start=%b cs=%b busy=%b wr=%b want 0/1111/0/0",
               eng_start, eng_cs, busy, eng_wr_en);
    end
    end_txn = 1'b1;
    step();
    end_txn = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rsp_valid !== 2'b00) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp) begin
      failures++;
      $display("FAIL rst_no_rsp: got rsp_valid after reset want none");
    end
    req_valid = 2'b11;
    step();
    checks++;
    if (req_grant !== 2'b01) begin
      failures++;
      $display("FAIL rst_first_grant: got %b want 01", req_grant);
    end
    req_valid = 2'b00;
    step();
    end_txn = 1'b1;
    rd_data = 16'h0BAD;
    step();
    end_txn = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rd_data !== 16'h0BAD) begin
      failures++;
      $display("FAIL rst_after_rsp: got v=%b d=%h want 01/0bad", rsp_valid, rsp_rd_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_timeout_collision();
    test_invalid_index();
    test_clk_en_stall();
    test_reset_mid_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
